// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
// Mode/set controller and timekeeping sequencer for the digital clock.
//
// Ports:
//   CP         system clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   tick       one-CP-wide 1 Hz pulse from the prescaler
//   key_mode   debounced mode key level (high while pressed)
//   key_inc    debounced increment key level (high while pressed)
//   time_hour  BCD hours 00..23
//   time_min   BCD minutes 00..59
//   time_sec   BCD seconds 00..59
//   alm_hour   BCD alarm hour
//   alm_min    BCD alarm minute
//   mode       current state: RUN=0 SET_H=1 SET_M=2 ALM_H=3 ALM_M=4
//   edit       field under edit, [1]=hour [0]=minute (display blinks these)
//   alm_en     alarm armed
//   ring       alarm sounding
//
// Key handshake: a key "press" is a single-cycle event, key & ~key_q, acting
// on the same edge that captures key_q. A held key yields one press. While
// ring is high any press only silences the alarm and is otherwise consumed.
// -----------------------------------------------------------------------------
module clock_ctrl #(
   parameter int         ALARM_LEN    = 60,
   parameter logic [7:0] ALM_RST_HOUR = 8'h07,
   parameter logic [7:0] ALM_RST_MIN  = 8'h00
) (
   input  logic       CP,
   input  logic       reset,
   input  logic       tick,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [7:0] time_hour,
   output logic [7:0] time_min,
   output logic [7:0] time_sec,
   output logic [7:0] alm_hour,
   output logic [7:0] alm_min,
   output logic [2:0] mode,
   output logic [1:0] edit,
   output logic       alm_en,
   output logic       ring
);

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      SET_H = 3'd1,
      SET_M = 3'd2,
      ALM_H = 3'd3,
      ALM_M = 3'd4
   } state_t;

   localparam logic [7:0] ALEN = 8'(ALARM_LEN);

   state_t     state, state_next;
   logic       key_mode_q, key_inc_q;
   logic       press_mode, press_inc;
   logic       silence, mode_act, inc_act;
   logic       keeping, step, sec_wrap, min_wrap, match;
   logic [7:0] sec_n, min_n, hour_n, alm_hour_n, alm_min_n;
   logic [1:0] edit_next;
   logic [7:0] ring_cnt;

   // Increment a two-digit BCD value, wrapping to 00 after 'last'.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
      if (v == last) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign mode = state;

   // Key decoding and next-state logic
   always_comb begin
      press_mode = key_mode & ~key_mode_q;
      press_inc  = key_inc & ~key_inc_q;
      silence    = ring & (press_mode | press_inc);
      mode_act   = press_mode & ~ring;
      // mode wins over a simultaneous inc
      inc_act    = press_inc & ~press_mode & ~ring;
      state_next = state;
      case (state)
         RUN:     if (mode_act) state_next = SET_H;
         SET_H:   if (mode_act) state_next = SET_M;
         SET_M:   if (mode_act) state_next = ALM_H;
         ALM_H:   if (mode_act) state_next = ALM_M;
         ALM_M:   if (mode_act) state_next = RUN;
         default: state_next = RUN;
      endcase
      case (state_next)
         SET_H, ALM_H: edit_next = 2'b10;
         SET_M, ALM_M: edit_next = 2'b01;
         default:      edit_next = 2'b00;
      endcase
   end

   // Timekeeping, field editing and alarm match
   always_comb begin
      keeping  = (state == RUN) || (state == ALM_H) || (state == ALM_M);
      step     = tick & keeping;
      sec_wrap = (time_sec == 8'h59);
      min_wrap = (time_min == 8'h59);
      sec_n    = step ? bcd_inc(time_sec, 8'h59) : time_sec;
      min_n    = (step & sec_wrap) ? bcd_inc(time_min, 8'h59) : time_min;
      hour_n   = (step & sec_wrap & min_wrap) ? bcd_inc(time_hour, 8'h23) : time_hour;
      // Only a tick-driven transition can fire; compares the stored alarm.
      match    = step & alm_en & (hour_n == alm_hour) & (min_n == alm_min) &
                 (sec_n == 8'h00);
      alm_hour_n = alm_hour;
      alm_min_n  = alm_min;
      if (inc_act) begin
         case (state)
            SET_H:   hour_n     = bcd_inc(time_hour, 8'h23);
            SET_M:   min_n      = bcd_inc(time_min, 8'h59);
            ALM_H:   alm_hour_n = bcd_inc(alm_hour, 8'h23);
            ALM_M:   alm_min_n  = bcd_inc(alm_min, 8'h59);
            default: ;
         endcase
      end
      if ((state == RUN) && (state_next == SET_H)) sec_n = 8'h00;
   end

   always_ff @(posedge CP or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= state_next;
   end

   always_ff @(posedge CP or negedge reset) begin
      if (!reset) begin
         key_mode_q <= 1'b0;
         key_inc_q  <= 1'b0;
         time_hour  <= 8'h00;
         time_min   <= 8'h00;
         time_sec   <= 8'h00;
         alm_hour   <= ALM_RST_HOUR;
         alm_min    <= ALM_RST_MIN;
         edit       <= 2'b00;
         alm_en     <= 1'b0;
         ring       <= 1'b0;
         ring_cnt   <= 8'd0;
      end else begin
         key_mode_q <= key_mode;
         key_inc_q  <= key_inc;
         time_hour  <= hour_n;
         time_min   <= min_n;
         time_sec   <= sec_n;
         alm_hour   <= alm_hour_n;
         alm_min    <= alm_min_n;
         edit       <= edit_next;
         if (inc_act && (state == RUN)) alm_en <= ~alm_en;
         // ring_cnt counts ticks after the matching one; the ALARM_LEN-th ends it.
         if (match) begin
            ring     <= 1'b1;
            ring_cnt <= 8'd0;
         end else if (silence) begin
            ring <= 1'b0;
         end else if (ring && tick) begin
            ring_cnt <= ring_cnt + 8'd1;
            if ((ring_cnt + 8'd1) == ALEN) ring <= 1'b0;
         end
      end
   end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Mode/set controller and timekeeping sequencer for the digital clock.
- Owns the BCD time registers (hh:mm:ss) and the alarm registers (hh:mm).
- Advances time on a 1 Hz tick pulse from the prescaler.
- Walks the user through time-set and alarm-set modes using two debounced keys.
- Raises the alarm ring output on a time match.
- Sits between the key debouncers, the prescaler and the 7-segment display mux.

Parameters:
ALARM_LEN, 60, number of ticks the ring output stays asserted (1..255)
ALM_RST_HOUR, 8'h07, BCD alarm hour loaded at reset (00..23)
ALM_RST_MIN, 8'h00, BCD alarm minute loaded at reset (00..59)

Ports:
CP  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
tick  input  1  one-CP-wide pulse, once per second
key_mode  input  1  debounced level, high while pressed
key_inc  input  1  debounced level, high while pressed
time_hour  output  8  BCD hours 00..23
time_min  output  8  BCD minutes 00..59
time_sec  output  8  BCD seconds 00..59
alm_hour  output  8  BCD alarm hour
alm_min  output  8  BCD alarm minute
mode  output  3  current state encoding (see below)
edit  output  2  field being edited: [1]=hour, [0]=minute; display blinks these
alm_en  output  1  alarm armed
ring  output  1  alarm sounding

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) forces:
  - time = 00:00:00
  - alarm = ALM_RST_HOUR:ALM_RST_MIN
  - mode = RUN
  - edit = 00, alm_en = 0, ring = 0
  - key history registers = 0
- Key edge detect:
  - Each key is registered every CP.
  - press = key & ~key_q.
  - The press acts at the same edge that captures key_q, so the output changes at the first CP edge where the key is high after a low sample.
  - A held key produces exactly one press.
- States and encodings: RUN=0, SET_H=1, SET_M=2, ALM_H=3, ALM_M=4.
  - key_mode press advances RUN->SET_H->SET_M->ALM_H->ALM_M->RUN.
  - Encodings 5..7 are unreachable; if entered, they return to RUN on the next edge.
- edit values: SET_H/ALM_H = 10; SET_M/ALM_M = 01; RUN = 00.
- Timekeeping (RUN, ALM_H, ALM_M), on a tick:
  - sec+1; at 59 it wraps to 00 and carries to min.
  - min 59 wraps to 00 and carries to hour.
  - hour 23 wraps to 00.
  - 23:59:59 -> 00:00:00 in a single edge.
  - BCD digits never hold values above 9.
- SET_H / SET_M:
  - tick is ignored; time is frozen.
  - time_sec is cleared to 00 on the edge entering SET_H.
  - key_inc press: hour+1 mod 24 (SET_H) or min+1 mod 60 (SET_M); no carry between fields.
- ALM_H / ALM_M:
  - key_inc press: alm_hour+1 mod 24 or alm_min+1 mod 60; no carry.
  - Timekeeping continues; a tick and an inc in the same cycle both apply.
- RUN: key_inc press toggles alm_en.
- Simultaneous key_mode and key_inc presses: mode wins, inc is discarded.
- Alarm match:
  - Checked in RUN, ALM_H and ALM_M only.
  - Condition: a tick produces new time == alm_hour:alm_min:00 while alm_en=1.
  - ring is set at that same edge and an internal tick counter is cleared.
  - ring stays high for exactly ALARM_LEN ticks, including the matching tick.
  - It clears at the edge of the ALARM_LEN-th following tick.
- Silence: while ring=1, any key press clears ring at that edge and is consumed, with no mode change, inc or toggle. alm_en is unchanged, so the alarm rearms for the next day.
- Editing the alarm to the current time does not fire; only a tick-driven transition fires.
- Reset mid-ring or mid-edit: immediate return to reset values.

Test Plan:
1. Reset, then 60 ticks in RUN -> time 00:01:00; 3600 more -> 01:01:00. Preload via SET to 23:59 then 59 ticks -> 23:59:59; next tick -> 00:00:00.
2. key_mode press (held 5 cycles) -> mode=1 and edit=10 after one edge, with no further advance while held. Ticks are ignored and sec=00. 25 key_inc presses -> hour 01 (mod 24). In SET_M, 60 presses from 00 -> min 00, hour unchanged.
3. key_mode and key_inc pressed in the same cycle in SET_H -> mode=2 and hour unchanged.
4. Alarm set to 00:02, RUN, key_inc press -> alm_en=1. At tick reaching 00:02:00 -> ring=1. ring is still high after 59 more ticks and drops at the 60th.
5. While ring=1, press key_mode -> ring=0 and mode stays RUN. A second key_mode press -> mode=1.
6. Assert reset asynchronously (no CP edge) during ALM_M with ring high -> all outputs at reset values immediately, with alarm = 07:00.
